// File: rtl/carry_increment_adder.sv
`default_nettype none
// ============================================================================
//  Module   : carry_increment_adder
//  Purpose  : Registered two-operand unsigned adder built as a carry-increment
//             structure. Each BLK-bit block ripple-adds its slice with
//             carry-in 0 and produces a block generate and propagate. A
//             half-adder incrementer then adds the incoming block carry.
//             Result and carry-out are registered, giving a 1-cycle stage.
//  Ports    : clk   - rising-edge clock
//             rst_n - asynchronous active-low reset, clears sum/cout(/ovf)
//             a, b  - WIDTH-bit unsigned operands
//             cin   - carry into bit 0
//             sum   - registered (a + b + cin) mod 2^WIDTH
//             cout  - registered carry out of bit WIDTH-1
//             ovf   - registered signed overflow (only with CIA_OVERFLOW_EN)
//  Options  : define CIA_OVERFLOW_EN to add the ovf output port.
//  Params   : WIDTH must be a multiple of BLK; BLK is one of 2, 4, 8, 16.
//  Revision : 1.0 - initial release
// ============================================================================
module carry_increment_adder #(
    parameter int WIDTH = 64,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CIA_OVERFLOW_EN
   ,output logic             ovf
`endif
);

    localparam int c_NB = WIDTH / BLK;

    // Per-block results of the carry-in-0 ripple add
    logic [WIDTH-1:0] w_s0;
    logic [c_NB-1:0]  w_g;
    logic [c_NB-1:0]  w_p;

    // Block carries (w_carry[k] enters block k) and final sum
    logic [c_NB:0]    w_carry;
    logic [WIDTH-1:0] w_sum;
    logic             w_inc;

    // ------------------------------------------------------------------------
    // Local block adders: independent of every other block, so they all
    // settle in parallel; only the short g/p chain below is serial.
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < c_NB; k++) begin : g_blk
        logic [BLK-1:0] w_as;
        logic [BLK-1:0] w_bs;
        logic [BLK-1:0] w_ls;
        logic [BLK:0]   w_rc;

        assign w_as = a[k*BLK +: BLK];
        assign w_bs = b[k*BLK +: BLK];

        always_comb begin
            w_rc    = '0;
            w_ls    = '0;
            w_rc[0] = 1'b0;
            for (int i = 0; i < BLK; i++) begin
                w_ls[i]   = w_as[i] ^ w_bs[i] ^ w_rc[i];
                w_rc[i+1] = (w_as[i] & w_bs[i]) | ((w_as[i] ^ w_bs[i]) & w_rc[i]);
            end
        end

        assign w_s0[k*BLK +: BLK] = w_ls;
        assign w_g[k]             = w_rc[BLK];
        assign w_p[k]             = &(w_as ^ w_bs);
    end

    // ------------------------------------------------------------------------
    // Block carry chain plus incrementer. The incrementer's own carry-out is
    // never needed: a block with carry-in 1 carries out exactly when it
    // generates or propagates, which the g/p recurrence already covers.
    // ------------------------------------------------------------------------
    always_comb begin
        w_carry    = '0;
        w_sum      = '0;
        w_inc      = 1'b0;
        w_carry[0] = cin;
        for (int k = 0; k < c_NB; k++) begin
            w_inc = w_carry[k];
            for (int i = 0; i < BLK; i++) begin
                w_sum[k*BLK+i] = w_s0[k*BLK+i] ^ w_inc;
                w_inc          = w_s0[k*BLK+i] & w_inc;
            end
            w_carry[k+1] = w_g[k] | (w_p[k] & w_carry[k]);
        end
    end

    // ------------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            r_sum  <= w_sum;
            r_cout <= w_carry[c_NB];
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

`ifdef CIA_OVERFLOW_EN
    // Like-signed operands producing a result of the other sign
    logic w_ovf;
    logic r_ovf;

    assign w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_ovf;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_carry_increment_adder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_carry_increment_adder
//  Purpose  : Scoreboard bench for carry_increment_adder (WIDTH=64, BLK=4).
//             The driver applies inputs on the falling edge and queues the
//             expected result; the monitor pops and compares 1 ns after each
//             rising edge, and checks for all-zero outputs while in reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_carry_increment_adder;

    localparam int WIDTH = 64;
    localparam int BLK   = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             dut_ovf;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
        string            name;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    carry_increment_adder #(.WIDTH(WIDTH), .BLK(BLK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout)
`ifdef CIA_OVERFLOW_EN
       ,.ovf   (dut_ovf)
`endif
    );

`ifndef CIA_OVERFLOW_EN
    assign dut_ovf = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ovf is only observable when the feature is built in
    function automatic logic ovf_en(input logic o);
`ifdef CIA_OVERFLOW_EN
        return o;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] es,
                         input logic ec, input logic eo);
        total++;
        if (sum !== es || cout !== ec || dut_ovf !== ovf_en(eo)) begin
            bad++;
            $display("FAIL %s: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                     name, sum, cout, dut_ovf, es, ec, ovf_en(eo));
        end
    endtask

    // Apply a vector on the falling edge with a hand-computed expectation
    task automatic drive(input string name, input logic [WIDTH-1:0] va,
                         input logic [WIDTH-1:0] vb, input logic vc,
                         input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        exp_t e;
        @(negedge clk);
        a = va; b = vb; cin = vc;
        e.s = es; e.c = ec; e.o = eo; e.name = name;
        exp_q.push_back(e);
    endtask

    // Apply a vector whose expectation comes from a reference model
    task automatic drive_model(input string name, input logic [WIDTH-1:0] va,
                               input logic [WIDTH-1:0] vb, input logic vc);
        logic [WIDTH:0] full;
        logic           o;
        full = {1'b0, va} + {1'b0, vb} + {{WIDTH{1'b0}}, vc};
        o    = (va[WIDTH-1] == vb[WIDTH-1]) && (full[WIDTH-1] != va[WIDTH-1]);
        drive(name, va, vb, vc, full[WIDTH-1:0], full[WIDTH], o);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                check("in_reset", '0, 1'b0, 1'b0);
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.name, e.s, e.c, e.o);
            end
        end
    end

    localparam logic [WIDTH-1:0] c_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_MSB  = {1'b1, {(WIDTH-1){1'b0}}};

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        // Reset held while operands are present
        rst_n = 1'b0;
        a = 64'd5; b = 64'd7; cin = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        total++;
        if (sum !== '0 || cout !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: got sum=%h cout=%b, want 0 0", sum, cout);
        end
        drive("reset_release", 64'd5, 64'd7, 1'b1, 64'd13, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Directed boundaries
        drive("full_carry", c_ONES, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0);
        drive("blk_cross", 64'h0000_0000_0000_000F, 64'd1, 1'b0, 64'h10, 1'b0, 1'b0);
        drive("zero_cin", 64'd0, 64'd0, 1'b1, 64'd1, 1'b0, 1'b0);
        drive("max_ops", c_ONES, c_ONES, 1'b1, c_ONES, 1'b1, 1'b0);
        drive("msb_msb", c_MSB, c_MSB, 1'b0, 64'd0, 1'b1, 1'b1);
        drive("sgn_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, c_MSB, 1'b0, 1'b1);
        drive("plain", 64'h1234, 64'h4321, 1'b0, 64'h5555, 1'b0, 1'b0);
        drive("mid_chain", 64'h0000_00FF_FFFF_FFF0, 64'h10, 1'b1,
              64'h0000_0100_0000_0001, 1'b0, 1'b0);

        // Counting sweep: a steps every 10 ns, b every 15 ns
        for (int i = 0; i < 60; i++) begin
            drive_model("sweep", 64'(i), 64'((i * 10) / 15), (i >= 20 && i < 40));
        end

        // Random traffic with an asynchronous reset pulse part-way through
        for (int i = 0; i < 10000; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            drive_model("random", ra, rb, 1'($urandom));
            if (i == 5000) begin
                #2;
                rst_n = 1'b0;
                #1;
                total++;
                if (sum !== '0 || cout !== 1'b0 || dut_ovf !== 1'b0) begin
                    bad++;
                    $display("FAIL async_reset: got sum=%h cout=%b ovf=%b, want 0 0 0",
                             sum, cout, dut_ovf);
                end
                exp_q.delete();
                repeat (3) @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        // Drain the scoreboard
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
